hex_line_decoder: RTL and testbench

HEX_LINE_DECODER -- requirements
Module: hex_line_decoder

---
 rtl/hex_line_decoder.sv | 108 ++++++++++
 tb/tb_hex_line_decoder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/hex_line_decoder.sv
// ASCII hex line parser: accumulates hex digits, delivers the value on CR/LF.
// Optional macro HEX_LOWERCASE_EN also accepts 'a'-'f' as digits.
module hex_line_decoder #(
    parameter int WIDTH = 16
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic [7:0]                         rx_data,
    input  logic                               rx_valid,
    output logic                               rx_ready,
    output logic [WIDTH-1:0]                   out_value,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [$clog2(WIDTH/4+1)-1:0]       out_digits,
    output logic                               err
);
    localparam int DIGITS = WIDTH / 4;
    localparam int CW     = $clog2(DIGITS + 1);

    typedef enum logic [1:0] {IDLE, ACCUM, DISCARD} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    count;
    logic             accept, is_digit, is_term, full;
    logic             bad_byte, line_done, take_digit;
    logic [3:0]       nibble;
    logic [WIDTH-1:0] acc_shift;

    always_comb begin
        is_digit = 1'b0;
        nibble   = 4'd0;
        if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
            is_digit = 1'b1;
            nibble   = rx_data[3:0];
        end else if (rx_data >= 8'h41 && rx_data <= 8'h46) begin
            is_digit = 1'b1;
            nibble   = rx_data[3:0] + 4'd9;
`ifdef HEX_LOWERCASE_EN
        end else if (rx_data >= 8'h61 && rx_data <= 8'h66) begin
            is_digit = 1'b1;
            nibble   = rx_data[3:0] + 4'd9;
`endif
        end
    end

    assign is_term    = (rx_data == 8'h0D) || (rx_data == 8'h0A);
    assign accept     = rx_valid && rx_ready;
    assign full       = (count == CW'(DIGITS));
    assign acc_shift  = (acc << 4) | WIDTH'(nibble);
    // Overflowing digits and non-hex bytes both poison the line; DISCARD itself never flags.
    assign bad_byte   = accept && (state != DISCARD) &&
                        ((is_digit && full) || (!is_digit && !is_term));
    assign take_digit = accept && (state != DISCARD) && is_digit && !full;
    assign line_done  = accept && (state == ACCUM) && is_term;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (accept) begin
            case (state)
                IDLE, ACCUM: begin
                    if (is_digit)     state_nxt = full ? DISCARD : ACCUM;
                    else if (is_term) state_nxt = IDLE;
                    else              state_nxt = DISCARD;
                end
                DISCARD: if (is_term) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        rx_ready = !(out_valid && !out_ready);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc        <= '0;
            count      <= '0;
            out_value  <= '0;
            out_digits <= '0;
            out_valid  <= 1'b0;
            err        <= 1'b0;
        end else begin
            err <= bad_byte;
            if (take_digit) begin
                acc   <= acc_shift;
                count <= count + CW'(1);
            end else if (accept && is_term) begin
                acc   <= '0;
                count <= '0;
            end
            // A new line may replace a value being handed off in the same cycle.
            if (line_done) begin
                out_value  <= acc;
                out_digits <= count;
                out_valid  <= 1'b1;
            end else if (out_ready) begin
                out_valid  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_hex_line_decoder.sv
// Randomized + directed bench for hex_line_decoder against a line-level model.
module tb_hex_line_decoder;
    localparam int WIDTH  = 16;
    localparam int DIGITS = WIDTH / 4;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [7:0]       rx_data = 8'h00;
    logic             rx_valid = 1'b0;
    logic             rx_ready;
    logic [WIDTH-1:0] out_value;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [2:0]       out_digits;
    logic             err;

    int errors = 0;
    int checks = 0;

    hex_line_decoder #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .out_value(out_value), .out_valid(out_valid),
        .out_ready(out_ready), .out_digits(out_digits), .err(err)
    );

    always #5 clk = ~clk;

    // Line-level model: digits of current line, poisoned flag, pending output.
    int         m_ndig;
    bit         m_bad;
    int         m_val;
    bit         m_ov;
    int         m_oval;
    int         m_odig;
    bit         m_err;
    int         m_lines;

    function automatic int hexval(input logic [7:0] c);
        string up = "0123456789ABCDEF";
        string lo = "0123456789abcdef";
        for (int i = 0; i < 16; i++) begin
            if (c == up[i]) return i;
`ifdef HEX_LOWERCASE_EN
            if (c == lo[i]) return i;
`endif
        end
        if (lo.len() == 0) return -2;
        return -1;
    endfunction

    task automatic model_reset();
        m_ndig = 0; m_bad = 0; m_val = 0; m_ov = 0;
        m_oval = 0; m_odig = 0; m_err = 0;
    endtask

    task automatic model_edge();
        bit took, prod, term;
        int d, pv, pd;
        if (!reset_n) begin
            model_reset();
            return;
        end
        took = rx_valid && !(m_ov && !out_ready);
        prod = 0; pv = 0; pd = 0;
        m_err = 0;
        if (took) begin
            d    = hexval(rx_data);
            term = (rx_data == 8'd13) || (rx_data == 8'd10);
            if (term) begin
                if (!m_bad && m_ndig > 0) begin
                    prod = 1; pv = m_val; pd = m_ndig; m_lines++;
                end
                m_bad = 0; m_ndig = 0; m_val = 0;
            end else if (!m_bad) begin
                if (d < 0 || m_ndig == DIGITS) begin
                    m_err = 1; m_bad = 1;
                end else begin
                    m_val = m_val * 16 + d;
                    m_ndig++;
                end
            end
        end
        if (prod) begin
            m_ov = 1; m_oval = pv; m_odig = pd;
        end else if (out_ready) begin
            m_ov = 0;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
        chk("err", {31'd0, err}, {31'd0, m_err});
        if (m_ov) begin
            chk("out_value", {16'd0, out_value}, m_oval);
            chk("out_digits", {29'd0, out_digits}, m_odig);
        end
    endtask

    // Called just after a falling edge; returns at the next falling edge.
    task automatic step(input bit v, input logic [7:0] d, input bit r);
        rx_valid = v; rx_data = d; out_ready = r;
        #1;
        if (reset_n) chk("rx_ready", {31'd0, rx_ready}, {31'd0, !(m_ov && !r)});
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic send(input string s, input bit r);
        for (int i = 0; i < s.len(); i++) step(1'b1, s[i], r);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_value"}, {16'd0, out_value}, 32'd0);
        chk({tag, "_digits"}, {29'd0, out_digits}, 32'd0);
        chk({tag, "_err"}, {31'd0, err}, 32'd0);
        chk({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd1);
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        check_zero_outputs("rst");
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [7:0] pool [0:19];
        string      cr = "\r";
        string      lf = "\n";
        int         n;
        pool = '{"0","1","5","9","A","C","F","a","e","G",
                 " ","z","3","7","B","D", 8'h0D, 8'h0A, 8'h0D, "8"};
        model_reset();
        m_lines = 0;
        @(negedge clk);
        check_zero_outputs("reset");
        step(1'b1, "1", 1'b1);
        check_zero_outputs("in_reset");
        reset_n = 1'b1;

        // "1A3F" CR
        send("1A3F", 1'b1);
        step(1'b1, cr[0], 1'b1);
        chk("l1_valid", {31'd0, out_valid}, 32'd1);
        chk("l1_value", {16'd0, out_value}, 32'h1A3F);
        chk("l1_digits", {29'd0, out_digits}, 32'd4);
        step(1'b0, 8'h00, 1'b1);
        chk("l1_clear", {31'd0, out_valid}, 32'd0);

        // "7" CR LF then "42" LF: CR LF yields one value
        n = m_lines;
        send({"7", cr, lf}, 1'b1);
        send("42", 1'b1);
        step(1'b1, lf[0], 1'b1);
        chk("l2_value", {16'd0, out_value}, 32'h0042);
        chk("l2_digits", {29'd0, out_digits}, 32'd2);
        chk("l2_count", m_lines - n, 32'd2);

        // Overflow on fifth digit
        send("1234", 1'b1);
        step(1'b1, "5", 1'b1);
        chk("ovf_err", {31'd0, err}, 32'd1);
        step(1'b1, lf[0], 1'b1);
        chk("ovf_noout", {31'd0, out_valid}, 32'd0);
        send({"9", lf}, 1'b1);
        chk("ovf_next", {16'd0, out_value}, 32'h0009);

        // Invalid char
        send("1G", 1'b1);
        chk("g_err", {31'd0, err}, 32'd1);
        step(1'b1, cr[0], 1'b1);
        chk("g_noout", {31'd0, out_valid}, 32'd0);
        send({"ab", cr}, 1'b1);
`ifdef HEX_LOWERCASE_EN
        chk("lc_value", {16'd0, out_value}, 32'h00AB);
`else
        chk("lc_noout", {31'd0, out_valid}, 32'd0);
`endif

        // Backpressure: held value, bytes not consumed
        step(1'b0, 8'h00, 1'b1);
        send({"5", cr}, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, "9", 1'b0);
            chk("bp_hold", {15'd0, out_valid, out_value}, 32'h10005);
        end
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, lf[0], 1'b1);
        chk("bp_noconsume", {31'd0, out_valid}, 32'd0);

        // Reset mid-line
        send("AB", 1'b1);
        pulse_reset();
        send({"C", cr}, 1'b1);
        chk("rst_value", {16'd0, out_value}, 32'h000C);
        chk("rst_digits", {29'd0, out_digits}, 32'd1);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) pulse_reset();
            step($urandom_range(0, 3) != 0, pool[$urandom_range(0, 19)],
                 $urandom_range(0, 9) < 7);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
